// File: rtl/adc_frame_capture.sv
// Serial ADC frame capture: frames each conversion with cs_n, shifts FRAME_BITS MSB first,
// and emits the low DATA_BITS as a sample with a one-cycle valid. Optional macro: ADC_LEAD_CHECK_EN.
module adc_frame_capture #(
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int LEAD_BITS    = FRAME_BITS - DATA_BITS,
  parameter int QUIET_CYCLES = 2
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
`ifdef ADC_LEAD_CHECK_EN
  output logic                 lead_err,
`endif
  output logic [15:0]          frame_cnt
);

  localparam int BC_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int QC_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] QUIET = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [QC_W-1:0]       quiet_cnt_q, quiet_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  cs_n_q, cs_n_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  lead_err_q, lead_err_d;

  // Complete frame as it stands once the current sdata bit is included.
  logic [FRAME_BITS-1:0] frame_word;
  assign frame_word = {shreg_q[FRAME_BITS-2:0], sdata};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    quiet_cnt_d    = quiet_cnt_q;
    shreg_d        = shreg_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    cs_n_d         = cs_n_q;
    frame_cnt_d    = frame_cnt_q;
    lead_err_d     = lead_err_q;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (enable) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
        end
      end

      SHIFT: begin
        shreg_d   = frame_word;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BC_W'(FRAME_BITS - 1)) begin
          sample_d       = frame_word[DATA_BITS-1:0];
          sample_valid_d = 1'b1;
          frame_cnt_d    = frame_cnt_q + 16'd1;
          lead_err_d     = |frame_word[FRAME_BITS-1 -: LEAD_BITS];
          cs_n_d         = 1'b1;
          state_d        = QUIET;
          quiet_cnt_d    = '0;
        end
      end

      QUIET: begin
        quiet_cnt_d = quiet_cnt_q + 1'b1;
        // Enable is only looked at on the last quiet cycle; earlier glitches are ignored.
        if (quiet_cnt_q == QC_W'(QUIET_CYCLES - 1)) begin
          if (enable) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            cs_n_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      quiet_cnt_q    <= '0;
      shreg_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      cs_n_q         <= 1'b1;
      frame_cnt_q    <= '0;
      lead_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      quiet_cnt_q    <= quiet_cnt_d;
      shreg_q        <= shreg_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      cs_n_q         <= cs_n_d;
      frame_cnt_q    <= frame_cnt_d;
      lead_err_q     <= lead_err_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q == SHIFT) || (state_q == QUIET);
  assign frame_cnt    = frame_cnt_q;

`ifdef ADC_LEAD_CHECK_EN
  assign lead_err = lead_err_q;
`else
  logic unused_lead;
  assign unused_lead = lead_err_q;
`endif

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture with a simple ADC serial model.
// Define ADC_LEAD_CHECK_EN to also exercise lead_err.
module tb_adc_frame_capture;

  localparam int FRAME_BITS   = 16;
  localparam int DATA_BITS    = 12;
  localparam int QUIET_CYCLES = 2;

  logic                 sclk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 sdata = 1'b0;
  logic                 cs_n;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 busy;
  logic [15:0]          frame_cnt;
`ifdef ADC_LEAD_CHECK_EN
  logic                 lead_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] cur_word = 16'h0000;
  int          bit_idx  = 0;

  adc_frame_capture #(
    .FRAME_BITS  (FRAME_BITS),
    .DATA_BITS   (DATA_BITS),
    .QUIET_CYCLES(QUIET_CYCLES)
  ) dut (
    .sclk        (sclk),
    .reset       (reset),
    .enable      (enable),
    .sdata       (sdata),
    .cs_n        (cs_n),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
`ifdef ADC_LEAD_CHECK_EN
    .lead_err    (lead_err),
`endif
    .frame_cnt   (frame_cnt)
  );

  always #20 sclk = ~sclk;

  // ADC model: presents the next bit MSB first on each falling edge while cs_n is low.
  always @(negedge sclk) begin
    if (cs_n) begin
      bit_idx = 0;
    end else if (bit_idx < FRAME_BITS) begin
      sdata   = cur_word[FRAME_BITS-1-bit_idx];
      bit_idx = bit_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Steps falling edges until sample_valid is seen, tallying cs_n levels on the way.
  task automatic run_until_valid(output int cyc, output int low_cnt, output int high_cnt);
    cyc = 0; low_cnt = 0; high_cnt = 0;
    while (cyc < 40) begin
      @(negedge sclk);
      cyc++;
      if (sample_valid) break;
      if (cs_n) high_cnt++; else low_cnt++;
    end
  endtask

  int cyc, low_cnt, high_cnt, valid_seen;
  logic [15:0] words [3] = '{16'h0123, 16'h0FFF, 16'h0000};
  logic [11:0] exp_s [3] = '{12'h123, 12'hFFF, 12'h000};

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge sclk);
    check("rst_cs_n",      32'(cs_n), 32'd1);
    check("rst_sample",    32'(sample), 32'd0);
    check("rst_valid",     32'(sample_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // First frame straight out of reset.
    cur_word = 16'h0ABC;
    reset    = 1'b0;
    run_until_valid(cyc, low_cnt, high_cnt);
    check("f1_latency",   32'(cyc), 32'd17);
    check("f1_cs_low",    32'(low_cnt), 32'd16);
    check("f1_sample",    32'(sample), 32'hABC);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f1_cs_n_at_v", 32'(cs_n), 32'd1);
    check("f1_busy_at_v", 32'(busy), 32'd1);

    // Back-to-back frames with enable held.
    for (int i = 0; i < 3; i++) begin
      cur_word = words[i];
      run_until_valid(cyc, low_cnt, high_cnt);
      check($sformatf("b2b%0d_period", i), 32'(cyc), 32'd18);
      check($sformatf("b2b%0d_cs_low", i), 32'(low_cnt), 32'd16);
      // One high cycle before the frame plus the valid cycle itself = QUIET_CYCLES.
      check($sformatf("b2b%0d_cs_high", i), 32'(high_cnt + 1), 32'(QUIET_CYCLES));
      check($sformatf("b2b%0d_sample", i), 32'(sample), 32'(exp_s[i]));
    end
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

    // Drop enable partway through a frame; it must still complete.
    cur_word = 16'h0555;
    cyc = 0;
    while (cs_n && cyc < 10) begin
      @(negedge sclk);
      cyc++;
    end
    check("drop_cs_low_seen", 32'(cs_n), 32'd0);
    repeat (5) @(negedge sclk);
    enable = 1'b0;
    run_until_valid(cyc, low_cnt, high_cnt);
    check("drop_latency",   32'(cyc), 32'd11);
    check("drop_sample",    32'(sample), 32'h555);
    check("drop_frame_cnt", 32'(frame_cnt), 32'd5);
    @(negedge sclk);
    check("drop_valid_1cyc", 32'(sample_valid), 32'd0);
    check("drop_q2_busy",    32'(busy), 32'd1);
    check("drop_q2_cs_n",    32'(cs_n), 32'd1);
    @(negedge sclk);
    check("drop_idle_busy",  32'(busy), 32'd0);
    check("drop_idle_cs_n",  32'(cs_n), 32'd1);
    repeat (3) @(negedge sclk);
    check("drop_stay_idle",  32'({busy, cs_n}), 32'b01);

    // Reset in the middle of a frame with enable still high.
    cur_word = 16'h0FA5;
    enable   = 1'b1;
    cyc = 0;
    while (cs_n && cyc < 10) begin
      @(negedge sclk);
      cyc++;
    end
    repeat (8) @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
    check("mid_rst_cs_n",      32'(cs_n), 32'd1);
    check("mid_rst_sample",    32'(sample), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_busy",      32'(busy), 32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    valid_seen = 0;
    repeat (40) begin
      @(negedge sclk);
      if (sample_valid) valid_seen++;
    end
    check("mid_rst_no_valid", 32'(valid_seen), 32'd0);

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge sclk);
    @(negedge sclk);
    release dut.frame_cnt_q;
    @(negedge sclk);
    check("wrap_preset", 32'(frame_cnt), 32'hFFFF);
    cur_word = 16'h0321;
    enable   = 1'b1;
    run_until_valid(cyc, low_cnt, high_cnt);
    enable = 1'b0;
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_sample",    32'(sample), 32'h321);
    repeat (3) @(negedge sclk);

`ifdef ADC_LEAD_CHECK_EN
    cur_word = 16'h8ABC;
    enable   = 1'b1;
    run_until_valid(cyc, low_cnt, high_cnt);
    check("lead_set_sample", 32'(sample), 32'hABC);
    check("lead_set_err",    32'(lead_err), 32'd1);
    cur_word = 16'h0ABC;
    run_until_valid(cyc, low_cnt, high_cnt);
    enable = 1'b0;
    check("lead_clr_sample", 32'(sample), 32'hABC);
    check("lead_clr_err",    32'(lead_err), 32'd0);
    repeat (3) @(negedge sclk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
